// File: rtl/hmc_rst_pkg.sv
// Shared types and default timing constants for the HMC reset sequencer.
package hmc_rst_pkg;

  typedef enum logic [2:0] {
    S_SYNC      = 3'd0,
    S_HOLD      = 3'd1,
    S_REL_HMC   = 3'd2,
    S_WAIT_LINK = 3'd3,
    S_RUN       = 3'd4
  } rst_state_e;

  localparam int unsigned HOLD_CYCLES_DEF = 16;
  localparam int unsigned USER_DELAY_DEF  = 8;
  localparam int unsigned WDOG_CYCLES_DEF = 1024;
  localparam int unsigned CNT_W_DEF       = 16;

  typedef struct packed {
    logic rst_n_hmc;
    logic rst_n_user;
    logic seq_done;
    logic soft_ack;
    logic wdog_trip;
  } rst_out_t;

  // Level outputs implied purely by the state that will be entered.
  function automatic rst_out_t levels_for(input rst_state_e s);
    rst_out_t o;
    o = '0;
    unique case (s)
      S_REL_HMC: o.rst_n_hmc = 1'b1;
      S_WAIT_LINK: begin
        o.rst_n_hmc  = 1'b1;
        o.rst_n_user = 1'b1;
      end
      S_RUN: begin
        o.rst_n_hmc  = 1'b1;
        o.rst_n_user = 1'b1;
        o.seq_done   = 1'b1;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/hmc_rst_sync.sv
// Two-flop reset synchronizer: asynchronous assert, deassert aligned to the clock.
module hmc_rst_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_rst_n_sync
);

  logic [1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[0], 1'b1};
    end
  end

  assign o_rst_n_sync = r_sync[1];

endmodule

// File: rtl/hmc_reset_sequencer.sv
// Sequences HMC/user resets from the raw board reset, with soft-reset re-run.
// Optional link-up watchdog enabled by defining HMC_RST_SEQ_WATCHDOG_EN.
module hmc_reset_sequencer
  import hmc_rst_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int unsigned USER_DELAY  = USER_DELAY_DEF,
  parameter int unsigned WDOG_CYCLES = WDOG_CYCLES_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic       clk_hmc,
  input  logic       res_n_hmc,
  input  logic       soft_rst_req,
  input  logic       link_up,
  output logic       rst_n_hmc_out,
  output logic       rst_n_user_out,
  output logic       soft_rst_ack,
  output logic       seq_done,
  output logic       wdog_trip,
  output logic [2:0] state_o
);

  if ((HOLD_CYCLES < 1) || (USER_DELAY < 1) || (WDOG_CYCLES < 1) ||
      ((HOLD_CYCLES >> CNT_W) != 32'd0) || ((USER_DELAY >> CNT_W) != 32'd0) ||
      ((WDOG_CYCLES >> CNT_W) != 32'd0)) begin : g_param_check
    $error("hmc_reset_sequencer: count parameter out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] USER_LAST = CNT_W'(USER_DELAY - 1);
`ifdef HMC_RST_SEQ_WATCHDOG_EN
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_CYCLES - 1);
`endif

  rst_state_e       r_state;
  rst_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_soft_take;
  logic             w_wdog_take;
  logic             w_rst_n_sync;
  rst_out_t         r_out;
  rst_out_t         w_out_nxt;

  hmc_rst_sync u_sync (
    .i_clk        (clk_hmc),
    .i_rst_n      (res_n_hmc),
    .o_rst_n_sync (w_rst_n_sync)
  );

  always_ff @(posedge clk_hmc or negedge res_n_hmc) begin
    if (!res_n_hmc) begin
      r_state <= S_SYNC;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_soft_take = 1'b0;
    w_wdog_take = 1'b0;
    if ((r_state != S_SYNC) && soft_rst_req) begin
      w_state_nxt = S_HOLD;
      w_cnt_nxt   = '0;
      w_soft_take = 1'b1;
    end else begin
      unique case (r_state)
        S_SYNC: begin
          w_cnt_nxt = '0;
          if (w_rst_n_sync) begin
            w_state_nxt = S_HOLD;
          end
        end
        S_HOLD: begin
          if (r_cnt == HOLD_LAST) begin
            w_state_nxt = S_REL_HMC;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        S_REL_HMC: begin
          if (r_cnt == USER_LAST) begin
            w_state_nxt = S_WAIT_LINK;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        S_WAIT_LINK: begin
          // link_up is tested first so it beats a timeout landing on the same edge
          if (link_up) begin
            w_state_nxt = S_RUN;
            w_cnt_nxt   = '0;
          end
`ifdef HMC_RST_SEQ_WATCHDOG_EN
          else if (r_cnt == WDOG_LAST) begin
            w_state_nxt = S_HOLD;
            w_cnt_nxt   = '0;
            w_wdog_take = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
`endif
        end
        S_RUN: begin
          w_state_nxt = S_RUN;
        end
        default: begin
          w_state_nxt = S_SYNC;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_comb begin
    w_out_nxt           = levels_for(w_state_nxt);
    w_out_nxt.soft_ack  = w_soft_take;
    w_out_nxt.wdog_trip = w_wdog_take;
  end

  always_ff @(posedge clk_hmc or negedge res_n_hmc) begin
    if (!res_n_hmc) begin
      r_out <= '0;
    end else begin
      r_out <= w_out_nxt;
    end
  end

  assign rst_n_hmc_out  = r_out.rst_n_hmc;
  assign rst_n_user_out = r_out.rst_n_user;
  assign seq_done       = r_out.seq_done;
  assign soft_rst_ack   = r_out.soft_ack;
  assign wdog_trip      = r_out.wdog_trip;
  assign state_o        = r_state;

endmodule

// File: tb/tb_hmc_reset_sequencer.sv
// Self-checking bench for hmc_reset_sequencer; models releases as edge-number offsets.
module tb_hmc_reset_sequencer;

  localparam int H  = 16;
  localparam int U  = 8;
  localparam int WD = 32;
`ifdef HMC_RST_SEQ_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  logic       clk_hmc      = 1'b0;
  logic       res_n_hmc    = 1'b0;
  logic       soft_rst_req = 1'b0;
  logic       link_up      = 1'b0;
  logic       rst_n_hmc_out, rst_n_user_out, soft_rst_ack, seq_done, wdog_trip;
  logic [2:0] state_o;

  always #5 clk_hmc = ~clk_hmc;

  hmc_reset_sequencer #(
    .HOLD_CYCLES (H),
    .USER_DELAY  (U),
    .WDOG_CYCLES (WD),
    .CNT_W       (16)
  ) dut (
    .clk_hmc        (clk_hmc),
    .res_n_hmc      (res_n_hmc),
    .soft_rst_req   (soft_rst_req),
    .link_up        (link_up),
    .rst_n_hmc_out  (rst_n_hmc_out),
    .rst_n_user_out (rst_n_user_out),
    .soft_rst_ack   (soft_rst_ack),
    .seq_done       (seq_done),
    .wdog_trip      (wdog_trip),
    .state_o        (state_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: edge count since release and the edge where holding began.
  int edge_n, start;
  bit started, done, e_ack, e_trip;

  // Observation trackers
  int hmc_rise, user_rise, done_rise, trip_edge, ack_cnt, trip_cnt, last_state;
  logic p_hmc, p_user, p_done;
  int state_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  task automatic model_reset();
    edge_n  = 0;
    started = 1'b0;
    done    = 1'b0;
    e_ack   = 1'b0;
    e_trip  = 1'b0;
  endtask

  task automatic model_edge();
    e_ack  = 1'b0;
    e_trip = 1'b0;
    edge_n++;
    if (!started) begin
      if (edge_n == 3) begin
        started = 1'b1;
        start   = edge_n;
        done    = 1'b0;
      end
    end else if (soft_rst_req) begin
      start = edge_n;
      done  = 1'b0;
      e_ack = 1'b1;
    end else if (!done && edge_n > start + H + U) begin
      if (link_up) begin
        done = 1'b1;
      end else if (WD_EN && edge_n == start + H + U + WD) begin
        e_trip = 1'b1;
        start  = edge_n;
      end
    end
  endtask

  function automatic int exp_state();
    if (!started) return 0;
    if (edge_n < start + H) return 1;
    if (edge_n < start + H + U) return 2;
    if (!done) return 3;
    return 4;
  endfunction

  task automatic check_all();
    chk("rst_n_hmc_out",  rst_n_hmc_out,  (started && edge_n >= start + H) ? 1 : 0);
    chk("rst_n_user_out", rst_n_user_out, (started && edge_n >= start + H + U) ? 1 : 0);
    chk("seq_done",       seq_done,       (exp_state() == 4) ? 1 : 0);
    chk("soft_rst_ack",   soft_rst_ack,   e_ack);
    chk("wdog_trip",      wdog_trip,      e_trip);
    chk("state_o",        state_o,        exp_state());
  endtask

  task automatic clear_trackers();
    hmc_rise = -1; user_rise = -1; done_rise = -1; trip_edge = -1;
    ack_cnt = 0; trip_cnt = 0; last_state = -1;
    state_q.delete();
  endtask

  task automatic tick();
    @(posedge clk_hmc);
    if (res_n_hmc) model_edge();
    #1;
    check_all();
    if (rst_n_hmc_out === 1'b1 && p_hmc !== 1'b1) hmc_rise = edge_n;
    if (rst_n_user_out === 1'b1 && p_user !== 1'b1) user_rise = edge_n;
    if (seq_done === 1'b1 && p_done !== 1'b1) done_rise = edge_n;
    if (soft_rst_ack === 1'b1) ack_cnt++;
    if (wdog_trip === 1'b1) begin trip_cnt++; trip_edge = edge_n; end
    if (int'(state_o) != last_state) begin
      state_q.push_back(int'(state_o));
      last_state = int'(state_o);
    end
    p_hmc = rst_n_hmc_out; p_user = rst_n_user_out; p_done = seq_done;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Called right after a tick; drops reset between edges and checks immediately.
  task automatic async_reset();
    #2;
    res_n_hmc = 1'b0;
    model_reset();
    #1;
    check_all();
    p_hmc = 1'b0; p_user = 1'b0; p_done = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clk_hmc);
    res_n_hmc = 1'b1;
  endtask

  task automatic soft_pulse(output int n_edge);
    soft_rst_req = 1'b1;
    tick();
    n_edge = edge_n;
    soft_rst_req = 1'b0;
  endtask

  initial begin
    int n, last_req, bias;
    model_reset();
    clear_trackers();
    p_hmc = 1'b0; p_user = 1'b0; p_done = 1'b0;

    // Reset state held for a few edges
    link_up = 1'b1;
    run(3);

    // Cold release with link already up
    clear_trackers();
    release_reset();
    run(32);
    chk("cold_hmc_rise_edge", hmc_rise, 19);
    chk("cold_user_rise_edge", user_rise, 27);
    chk("cold_done_rise_edge", done_rise, 28);
    chk("cold_state_steps", state_q.size(), 5);
    for (int i = 0; i < state_q.size() && i < 5; i++) chk("cold_state_step", state_q[i], i);

    // Single soft pulse from S_RUN
    clear_trackers();
    soft_pulse(n);
    run(30);
    chk("soft_ack_count", ack_cnt, 1);
    chk("soft_hmc_rise", hmc_rise, n + H);
    chk("soft_user_rise", user_rise, n + H + U);

    // Hard reset while in S_REL_HMC, then full re-sequence
    soft_pulse(n);
    for (int i = 0; i < 40 && state_o !== 3'd2; i++) tick();
    chk("reach_rel_hmc", state_o, 2);
    async_reset();
    run(2);
    clear_trackers();
    release_reset();
    run(32);
    chk("rerun_hmc_rise_edge", hmc_rise, 19);
    chk("rerun_user_rise_edge", user_rise, 27);
    chk("rerun_done_rise_edge", done_rise, 28);

    // Soft request held for five edges during S_HOLD
    soft_pulse(n);
    run(3);
    clear_trackers();
    soft_rst_req = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    last_req = edge_n;
    soft_rst_req = 1'b0;
    run(25);
    chk("held_soft_acks", ack_cnt, 5);
    chk("held_soft_hmc_rise", hmc_rise, last_req + H);

    // Link never comes up: watchdog trips in its build, waits forever otherwise
    link_up = 1'b0;
    clear_trackers();
    soft_pulse(n);
    run(H + U + WD + 10);
    if (WD_EN) begin
      chk("wdog_trip_count", trip_cnt, 1);
      chk("wdog_trip_edge", trip_edge, n + H + U + WD);
    end else begin
      chk("no_wdog_trip", trip_cnt, 0);
      chk("wait_link_state", state_o, 3);
    end

    // link_up arriving on the timeout edge wins
    clear_trackers();
    soft_pulse(n);
    run(H + U + WD - 1);
    link_up = 1'b1;
    tick();
    chk("timeout_edge_state", state_o, 4);
    chk("timeout_edge_no_trip", trip_cnt, 0);

    // Randomized traffic, including occasional asynchronous hard resets
    bias = 30;
    for (int i = 0; i < 900; i++) begin
      if (i % 150 == 0) bias = (i / 150) % 3 == 0 ? 2 : ((i / 150) % 3 == 1 ? 0 : 40);
      soft_rst_req = ($urandom_range(0, 39) == 0);
      link_up      = ($urandom_range(0, 99) < bias);
      if (!res_n_hmc) begin
        release_reset();
      end else if ($urandom_range(0, 199) == 0) begin
        async_reset();
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
